// File: rtl/seqdet_rr_scheduler.sv
// Round-robin scheduler sharing one "110011" overlapping sequence detector across
// NCH serial channels; per-channel detector state is saved and restored each grant.
module seqdet_rr_scheduler #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CW   = 2,
    parameter int unsigned CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  req_valid,
    input  logic [NCH-1:0]  req_bit,
    output logic [NCH-1:0]  req_ready,
    input  logic [NCH-1:0]  chan_clr,
    output logic            det_valid,
    output logic [CW-1:0]   det_ch,
    output logic            det_hit,
    output logic [CNTW-1:0] hit_cnt
);

    localparam logic [2:0] S0     = 3'd0;
    localparam logic [2:0] S1     = 3'd1;
    localparam logic [2:0] S11    = 3'd2;
    localparam logic [2:0] S110   = 3'd3;
    localparam logic [2:0] S1100  = 3'd4;
    localparam logic [2:0] S11001 = 3'd5;

    logic [CW-1:0]   ptr_q, ptr_d;
    logic [2:0]      ctx_q [NCH];
    logic [2:0]      ctx_d [NCH];
    logic            det_valid_q, det_valid_d;
    logic [CW-1:0]   det_ch_q, det_ch_d;
    logic            det_hit_q, det_hit_d;
    logic [CNTW-1:0] hit_cnt_q, hit_cnt_d;

    logic            gnt_any;
    logic [CW-1:0]   gnt_idx;
    logic [CW-1:0]   cand;
    logic [2:0]      cur_st;
    logic [2:0]      nxt_st;
    logic            gnt_bit;
    logic            hit_raw;

    // Rotating priority search starting at ptr; suppressed while in reset.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (reset) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                cand = CW'((32'(ptr_q) + k) % NCH);
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Shared detector datapath operating on the granted channel's context.
    always_comb begin
        cur_st  = ctx_q[gnt_idx];
        gnt_bit = req_bit[gnt_idx];
        nxt_st  = S0;
        case (cur_st)
            S0:      nxt_st = gnt_bit ? S1     : S0;
            S1:      nxt_st = gnt_bit ? S11    : S0;
            S11:     nxt_st = gnt_bit ? S11    : S110;
            S110:    nxt_st = gnt_bit ? S1     : S1100;
            S1100:   nxt_st = gnt_bit ? S11001 : S0;
            S11001:  nxt_st = gnt_bit ? S11    : S0;
            default: nxt_st = gnt_bit ? S1     : S0;
        endcase
        hit_raw = (cur_st == S11001) && gnt_bit;
    end

    always_comb begin
        ptr_d       = ptr_q;
        det_valid_d = gnt_any;
        det_ch_d    = gnt_idx;
        det_hit_d   = 1'b0;
        hit_cnt_d   = hit_cnt_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            ctx_d[i] = ctx_q[i];
        end

        if (gnt_any) begin
            ptr_d          = CW'((32'(gnt_idx) + 32'd1) % NCH);
            ctx_d[gnt_idx] = nxt_st;
            det_hit_d      = hit_raw && !chan_clr[gnt_idx];
        end

        // A clear wins over the update, discarding a coincident granted bit.
        for (int unsigned i = 0; i < NCH; i++) begin
            if (chan_clr[i]) begin
                ctx_d[i] = S0;
            end
        end

        if (det_hit_d && (hit_cnt_q != {CNTW{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            det_hit_q   <= 1'b0;
            hit_cnt_q   <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                ctx_q[i] <= S0;
            end
        end else begin
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            det_hit_q   <= det_hit_d;
            hit_cnt_q   <= hit_cnt_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
        end
    end

    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign det_hit   = det_hit_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_seqdet_rr_scheduler.sv
// Bench for seqdet_rr_scheduler: per-channel bit streams, an independent shift-history
// reference model, and a queue of expected detector outputs checked one cycle later.
module tb_seqdet_rr_scheduler;

    localparam int NCH  = 4;
    localparam int CW   = 2;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCH-1:0]  req_valid;
    logic [NCH-1:0]  req_bit;
    logic [NCH-1:0]  req_ready;
    logic [NCH-1:0]  chan_clr;
    logic            det_valid;
    logic [CW-1:0]   det_ch;
    logic            det_hit;
    logic [CNTW-1:0] hit_cnt;

    seqdet_rr_scheduler #(.NCH(NCH), .CW(CW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_ready (req_ready),
        .chan_clr  (chan_clr),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .det_hit   (det_hit),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [1:0] ch;
        logic       h;
    } exp_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad   = 0;

    // Reference model: the last six bits since clear/reset; a hit is a full 110011 window.
    int          ptr_m;
    logic [5:0]  hist[NCH];
    int          len[NCH];
    int          cnt_m;

    logic [31:0] sbits[NCH];
    int          slen[NCH];
    int          spos[NCH];

    int          cyc;
    int          hits_seen;
    int          last_hit_ch;
    int          hit_cyc[NCH];

    task automatic clear_obs();
        cyc = 0;
        hits_seen = 0;
        last_hit_ch = -1;
        for (int i = 0; i < NCH; i++) hit_cyc[i] = -1;
    endtask

    task automatic load(input int ch, input logic [31:0] pat, input int n);
        sbits[ch] = pat;
        slen[ch]  = n;
        spos[ch]  = 0;
    endtask

    function automatic bit pending();
        for (int i = 0; i < NCH; i++) if (spos[i] < slen[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic [NCH-1:0] clr);
        logic [NCH-1:0] v;
        logic [NCH-1:0] b;
        logic [NCH-1:0] exp_rdy;
        int             g;
        exp_t           e;
        logic           hit;
        for (int i = 0; i < NCH; i++) begin
            v[i] = (spos[i] < slen[i]);
            b[i] = v[i] ? sbits[i][slen[i]-1-spos[i]] : 1'b0;
        end
        req_valid = v;
        req_bit   = b;
        chan_clr  = clr;
        #1;
        g = -1;
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && v[(ptr_m + k) % NCH]) g = (ptr_m + k) % NCH;
            end
        end
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        total++;
        if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL grant cyc=%0d actual=%b required=%b", cyc, req_ready, exp_rdy);
        end
        e = '0;
        if (!reset) begin
            ptr_m = 0;
            cnt_m = 0;
            for (int i = 0; i < NCH; i++) begin
                len[i]  = 0;
                hist[i] = '0;
            end
        end else begin
            if (g >= 0) begin
                hit = !clr[g] && (len[g] >= 5) && ({hist[g][4:0], b[g]} == 6'b110011);
                e = '{v: 1'b1, ch: 2'(g), h: hit};
                hist[g] = {hist[g][4:0], b[g]};
                if (len[g] < 6) len[g]++;
                ptr_m = (g + 1) % NCH;
                spos[g]++;
                if (hit && cnt_m < 255) cnt_m++;
            end
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    len[i]  = 0;
                    hist[i] = '0;
                end
            end
        end
        expq.push_back(e);

        @(posedge clk);
        #1;
        e = expq.pop_front();
        total++;
        if (det_valid !== e.v) begin
            bad++;
            $display("FAIL det_valid cyc=%0d actual=%b required=%b", cyc, det_valid, e.v);
        end
        if (e.v) begin
            total++;
            if (det_ch !== e.ch) begin
                bad++;
                $display("FAIL det_ch cyc=%0d actual=%0d required=%0d", cyc, det_ch, e.ch);
            end
        end
        total++;
        if (det_hit !== e.h) begin
            bad++;
            $display("FAIL det_hit cyc=%0d actual=%b required=%b", cyc, det_hit, e.h);
        end
        total++;
        if (hit_cnt !== CNTW'(cnt_m)) begin
            bad++;
            $display("FAIL hit_cnt cyc=%0d actual=%0d required=%0d", cyc, hit_cnt, cnt_m);
        end
        if (det_hit === 1'b1) begin
            hits_seen++;
            last_hit_ch = int'(det_ch);
            hit_cyc[det_ch] = cyc + 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int maxc);
        int n = 0;
        while (pending() && n < maxc) begin
            step('0);
            n++;
        end
        total++;
        if (pending()) begin
            bad++;
            $display("FAIL drain_timeout actual=%0d cycles required=<%0d", n, maxc);
            for (int i = 0; i < NCH; i++) slen[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step('0);
        reset = 1'b1;
        clear_obs();
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_int("reset_ready", int'(req_ready), 0);
        check_int("reset_det_valid", int'(det_valid), 0);
        check_int("reset_det_hit", int'(det_hit), 0);
        check_int("reset_hit_cnt", int'(hit_cnt), 0);
    endtask

    task automatic test_single();
        do_reset();
        load(0, 32'b110011, 6);
        run(20);
        check_int("t1_hits", hits_seen, 1);
        check_int("t1_ch", last_hit_ch, 0);
        check_int("t1_hit_cycle", hit_cyc[0], 6);
        check_int("t1_hit_cnt", int'(hit_cnt), 1);
    endtask

    task automatic test_overlap();
        do_reset();
        load(1, 32'b1100110011, 10);
        run(20);
        check_int("t2_hits", hits_seen, 2);
        check_int("t2_last_cycle", hit_cyc[1], 10);
        check_int("t2_hit_cnt", int'(hit_cnt), 2);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < NCH; i++) load(i, 32'b110011, 6);
        run(40);
        check_int("t3_hits", hits_seen, 4);
        for (int i = 0; i < NCH; i++) check_int($sformatf("t3_hit_cycle_ch%0d", i), hit_cyc[i], 21 + i);
        check_int("t3_hit_cnt", int'(hit_cnt), 4);
    endtask

    task automatic test_interleave();
        do_reset();
        load(0, 32'b1100, 4); run(10);
        load(2, 32'b11, 2);   run(10);
        load(0, 32'b11, 2);   run(10);
        check_int("t4_hits", hits_seen, 1);
        check_int("t4_ch", last_hit_ch, 0);
        load(2, 32'b0011, 4); run(10);
        check_int("t4_ch2_ctx_hits", hits_seen, 2);
        check_int("t4_ch2_ctx_ch", last_hit_ch, 2);
    endtask

    task automatic test_clear();
        do_reset();
        load(3, 32'b11001, 5); run(10);
        step(4'b1000);
        load(3, 32'b1, 1); run(10);
        check_int("t5_clr_hits", hits_seen, 0);
        load(3, 32'b11001, 5); run(10);
        load(3, 32'b1, 1);
        step(4'b1000);
        check_int("t5_coinc_valid", int'(det_valid), 1);
        check_int("t5_coinc_hit", int'(det_hit), 0);
        load(3, 32'b1, 1); run(10);
        check_int("t5_after_hits", hits_seen, 0);
        check_int("t5_hit_cnt", int'(hit_cnt), 0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        load(0, 32'b11001, 5); run(10);
        load(1, 32'b1, 1);
        reset = 1'b0;
        step('0);
        reset = 1'b1;
        clear_obs();
        check_int("t6_det_valid", int'(det_valid), 0);
        check_int("t6_det_ch", int'(det_ch), 0);
        check_int("t6_det_hit", int'(det_hit), 0);
        check_int("t6_hit_cnt", int'(hit_cnt), 0);
        load(0, 32'b1, 1); run(10);
        check_int("t6_no_hit", hits_seen, 0);
    endtask

    task automatic test_saturate();
        do_reset();
        load(0, 32'b110011, 6); run(10);
        for (int n = 0; n < 299; n++) begin
            load(0, 32'b0011, 4);
            run(10);
        end
        check_int("sat_hits_seen", hits_seen, 300);
        check_int("sat_hit_cnt", int'(hit_cnt), 255);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_bit   = '0;
        chan_clr  = '0;
        ptr_m     = 0;
        cnt_m     = 0;
        for (int i = 0; i < NCH; i++) begin
            hist[i] = '0;
            len[i]  = 0;
            sbits[i] = '0;
            slen[i] = 0;
            spos[i] = 0;
        end
        clear_obs();
        @(negedge clk);
        test_reset();
        test_single();
        test_overlap();
        test_back_to_back();
        test_interleave();
        test_clear();
        test_mid_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
